alu_div_unit: RTL
=================

# alu_div_unit

Multi-cycle integer divider implementing RV32M DIV, DIVU, REM and REMU, the division codes that ALU_op already defines but the single-cycle ALU does not execute. It sits in the EX stage beside the ALU. It accepts the same 5-bit ALU operation code and the two EX operands, holds the pipeline via `busy` while it iterates, and returns a 32-bit result with a one-cycle `done` pulse. Algorithm: radix-2 restoring division on operand magnitudes, followed by a sign-fixup step.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request to begin a division.
- `op`  in  5  ALU operation code (`ALU_DIV`, `ALU_DIVU`, `ALU_REM` or `ALU_REMU`).
- `a`  in  32  dividend (rs1).
- `b`  in  32  divisor (rs2).
- `flush`  in  1  pipeline kill; aborts the operation in flight.
- `busy`  out  1  high while the operation is in flight; EX stalls on it.
- `done`  out  1  single-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  quotient or remainder; registered.

## Operation
- States:
  - IDLE
  - CALC, 32 iterations
  - FIX, sign correction
  - DONE
- Accept condition: `start`=1, state is IDLE or DONE, `flush`=0, and `op` is one of the four division codes.
- Any other `op` with `start`=1 is ignored; the state does not change.
- On accept, latch `op`, `a` and `b`.
- Signed ops (DIV, REM):
  - Operate on the magnitudes |a| and |b|.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- CALC, once per cycle:
  - Shift the remainder/quotient pair left by one.
  - Trial-subtract the divisor magnitude.
  - Keep the difference if it is non-negative; set quotient bit = 1 if so.
  - An iteration counter of 6 bits runs from 0 to 31; leave CALC when it reaches 31.
- FIX:
  - Apply the sign correction.
  - Select the quotient (DIV, DIVU) or the remainder (REM, REMU).
  - Register the selection into `result`.
- Special cases are detected at accept; they bypass CALC and FIX and go directly to DONE:
  - `b`=0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give `a`.
  - DIV with `a`=0x80000000 and `b`=0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state is IDLE, or CALC/DONE if a new start is accepted in this cycle (back-to-back operation).
- `result` holds its value until the next FIX or special-case load.
- `flush`=1 in any state:
  - Next state is IDLE; `done` is not asserted for the aborted operation.
  - `result` is unchanged.
  - If `flush` and `start` are both high, `flush` wins.
- `rst`=1:
  - Next state is IDLE, counter = 0, `result` = 0.
  - This applies mid-operation too; no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0x00000000.
- `start` is sampled at edge 0; the operation then proceeds by cycle:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, with `done`=1 and `result` valid.
- Normal latency is 34 cycles, start to `done`.
- Special cases: DONE in cycle 1, latency 1.
- `busy` is a registered-state decode:
  - `busy`=1 in CALC and FIX.
  - `busy`=0 in IDLE and DONE.
  - For a normal operation, `busy` rises in the cycle after the accept edge. EX must not assume `busy` in the accept cycle; the control unit asserts the stall combinationally from `start`.
- Back-to-back issue: a start accepted in the DONE cycle begins CALC in the next cycle, so there is no bubble.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.

## Structure
- `defines.v` owns the shared constants:
  - `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`; these already exist and are reused unchanged.
  - The `F3_DIV`…`F3_REMU` encodings.
- Local parameters in this module: the four state encodings (2 bits) and the iteration count 32.
- This change enables the matching cases in ALU_op; no new op codes are added.
- One combinational sub-module, `div_step`:
  - Inputs: 33-bit partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
- Everything else lives in `alu_div_unit`.

## Test plan
- DIV, 100 / 7 → `result`=14. `done` is high only in cycle 34; `busy` is high in cycles 1–33.
- REM, −7 % 2 → `result`=0xFFFFFFFF (−1). DIV, −7 / 2 → `result`=0xFFFFFFFD (−3).
- DIVU, 0xFFFFFFFF / 2 → `result`=0x7FFFFFFF. REMU, 0xFFFFFFFF % 16 → `result`=0xF.
- Divide by zero:
  - DIV, 5 / 0 → 0xFFFFFFFF.
  - REMU, 0x1234 % 0 → 0x1234.
  - DIV, 0x80000000 / −1 → 0x80000000; REM with the same operands → 0.
  - Each completes with `done` in cycle 1.
- Abort:
  - `flush` in cycle 10 of a DIV: `busy`=0 from cycle 11, no `done`, `result` unchanged.
  - `rst` in cycle 20: all outputs 0 from the next cycle.
- Issue rules:
  - `start` with `op`=`ALU_ADD` → stays IDLE, no `done`.
  - A second `start` in the DONE cycle → its `done` appears exactly 34 cycles later.
  - `start` while `busy`=1 → ignored.

Source files
------------

// File: rtl/alu_div_unit_pkg.sv
// Shared constants and types for the EX-stage multi-cycle divider.
// ALU op codes and RV32M funct3 encodings live here for reuse.
package alu_div_unit_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_div_unit_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   diff;

  assign shifted  = {rem, dvd_bit};
  assign q_bit    = shifted >= {2'b00, dvs};
  assign diff     = shifted[XLEN:0] - {1'b0, dvs};
  assign rem_next = q_bit ? diff : shifted[XLEN:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) beside the EX ALU.
// Restoring division on magnitudes, then a sign-fixup cycle.
module alu_div_unit
  import alu_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST    = 6'(DIV_ITERS - 1);

  div_state_e      state, state_n;
  logic [4:0]      op_q;
  logic            q_neg, r_neg;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo, dvs;
  logic [5:0]      cnt;

  logic            accept, special;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] spec_val, fix_val;
  logic [XLEN-1:0] q_fix, r_fix;
  logic [XLEN:0]   rem_n;
  logic            q_bit;

  assign accept = start && !flush && is_div_op(op) &&
                  (state == S_IDLE || state == S_DONE);

  assign a_neg = is_signed_op(op) && a[XLEN-1];
  assign b_neg = is_signed_op(op) && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Zero divisor and signed overflow never enter CALC.
  assign special = (b == '0) ||
                   (is_signed_op(op) && a == INT_MIN && b == '1);

  always_comb begin
    spec_val = '0;
    if (b == '0)
      spec_val = is_rem_op(op) ? a : '1;
    else if (op == ALU_DIV)
      spec_val = INT_MIN;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .dvd_bit  (quo[XLEN-1]),
    .dvs      (dvs),
    .rem_next (rem_n),
    .q_bit    (q_bit)
  );

  assign q_fix   = q_neg ? -quo : quo;
  assign r_fix   = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign fix_val = is_rem_op(op_q) ? r_fix : q_fix;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_n = special ? S_DONE : S_CALC;
        else
          state_n = S_IDLE;
      end
      S_CALC: if (cnt == LAST) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (flush)
      state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      rem   <= '0;
      quo   <= a_mag;
      dvs   <= b_mag;
      cnt   <= '0;
      if (special)
        result <= spec_val;
    end else if (!flush && state == S_CALC) begin
      rem <= rem_n;
      quo <= {quo[XLEN-2:0], q_bit};
      cnt <= cnt + 6'd1;
    end else if (!flush && state == S_FIX) begin
      result <= fix_val;
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule
